// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: iterative AES-128 decrypt key scheduler, emits round keys 10..0
//
// Runs the forward key expansion for NR cycles to reach round key 10. It then walks the
// schedule backwards one inverse step per accepted output, so no 11-entry key store is needed.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   key_valid_i    cipher key offered; taken only when key_ready_o is high
//   key_ready_o    block idle and able to accept a key
//   key_i          128-bit cipher key, key_i[127:120] is byte 0
//   rk_valid_o     round key on rk_o is valid
//   rk_ready_i     consumer accepts rk_o this cycle
//   rk_o           round key, same byte order as key_i
//   rk_round_o     round index of rk_o (10 down to 0)
//   busy_o         high whenever the block is not idle
//   done_o         one-cycle pulse after round key 0 is accepted
//
// Build option: define INV_MC_KEY_EN to emit InvMixColumns(round key) for rounds 9..1
// (equivalent inverse cipher). Rounds 10 and 0 are always emitted unchanged.
module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [127:0] key_i,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_round_o,
    output logic         busy_o,
    output logic         done_o
);
    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Rcon bytes indexed by round 0..10; entry 0 is never used.
    localparam logic [0:87] RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;

    state_t       state_q, state_d;
    logic [127:0] w_q, w_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    // SubWord(RotWord(x)) ^ {Rcon, 24'h0}
    function automatic logic [31:0] g(input logic [31:0] x, input logic [3:0] r);
        return {sbox(x[23:16]) ^ RCON[{r, 3'b000} +: 8], sbox(x[15:8]), sbox(x[7:0]), sbox(x[31:24])};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] w, input logic [3:0] r);
        logic [31:0] w0, w1, w2;
        w0 = w[127:96] ^ g(w[31:0], r);
        w1 = w[95:64] ^ w0;
        w2 = w[63:32] ^ w1;
        return {w0, w1, w2, w[31:0] ^ w2};
    endfunction

    // Undo the forward step: later words first, since w0 needs the recovered w3.
    function automatic logic [127:0] inv_step(input logic [127:0] w, input logic [3:0] r);
        logic [31:0] w3;
        w3 = w[31:0] ^ w[63:32];
        return {w[127:96] ^ g(w3, r), w[95:64] ^ w[127:96], w[63:32] ^ w[95:64], w3};
    endfunction

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (key_valid_i) begin
                state_d = EXPAND;
                w_d     = key_i;
                cnt_d   = 4'd1;
            end
            EXPAND: begin
                w_d   = fwd_step(w_q, cnt_q);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    state_d = EMIT;
                    cnt_d   = 4'd0;
                    rnd_d   = LAST;
                end
            end
            EMIT: if (rk_ready_i) begin
                if (rnd_q == 4'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    w_d   = inv_step(w_q, rnd_q);
                    rnd_d = rnd_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign key_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign rk_valid_o  = state_q == EMIT;
    assign rk_round_o  = rnd_q;
    assign done_o      = done_q;

`ifdef INV_MC_KEY_EN
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant k (bit i selects a*2^i).
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        return (k[0] ? a : 8'h00) ^ (k[1] ? xt(a) : 8'h00) ^ (k[2] ? xt(xt(a)) : 8'h00) ^
               (k[3] ? xt(xt(xt(a))) : 8'h00);
    endfunction

    function automatic logic [7:0] imc_b(input logic [7:0] a, b, c, d);
        return gm(a, 4'he) ^ gm(b, 4'hb) ^ gm(c, 4'hd) ^ gm(d, 4'h9);
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] x);
        return {imc_b(x[31:24], x[23:16], x[15:8], x[7:0]), imc_b(x[23:16], x[15:8], x[7:0], x[31:24]),
                imc_b(x[15:8], x[7:0], x[31:24], x[23:16]), imc_b(x[7:0], x[31:24], x[23:16], x[15:8])};
    endfunction

    assign rk_o = !rk_valid_o ? '0 :
                  (rnd_q == LAST || rnd_q == 4'd0) ? w_q :
                  {imc_col(w_q[127:96]), imc_col(w_q[95:64]), imc_col(w_q[63:32]), imc_col(w_q[31:0])};
`else
    assign rk_o = rk_valid_o ? w_q : '0;
`endif
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: self-checking bench against a software AES-128 key expansion model
module tb_aes_inv_key_sched;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         rk_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready, rk_valid, busy, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk(clk), .rst_n(rst_n), .key_valid_i(key_valid), .key_ready_o(key_ready),
        .key_i(key_in), .rk_valid_o(rk_valid), .rk_ready_i(rk_ready), .rk_o(rk_out),
        .rk_round_o(rk_round), .busy_o(busy), .done_o(done)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    logic [7:0]   sb_m[256];
    logic [127:0] mk[11];
    logic [127:0] got_k[11];
    logic [3:0]   got_r[11];
    int           first_cyc;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h63;
            for (int n = 0; n < 5; n++) s ^= 8'((inv << n) | (inv >> (8 - n)));
            sb_m[x] = s;
        end
    endtask

    task automatic expand_m(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_m[t[31:24]] ^ rc, sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) mk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] imc_m(input logic [127:0] rk);
        logic [7:0]   a[4];
        logic [127:0] o;
        logic [7:0]   m[4];
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = rk[127 - 32 * c - 8 * i -: 8];
            for (int i = 0; i < 4; i++)
                o[127 - 32 * c - 8 * i -: 8] = gmul(a[i], m[0]) ^ gmul(a[(i + 1) % 4], m[1]) ^
                                               gmul(a[(i + 2) % 4], m[2]) ^ gmul(a[(i + 3) % 4], m[3]);
        end
        return o;
    endfunction

    function automatic logic [127:0] xf(input logic [127:0] rk, input int r);
`ifdef INV_MC_KEY_EN
        return (r >= 1 && r <= 9) ? imc_m(rk) : rk;
`else
        return (r >= 0) ? rk : '0;
`endif
    endfunction

    // Runs one key through the block. On return the bench sits at the done cycle's sample point.
    // pre: key already offered in this cycle; junk: offer random keys while busy;
    // b2b: present nkey during the final accept so it is taken in the done cycle.
    task automatic run(input logic [127:0] key, input int pct, input bit junk, input bit pre,
                       input bit b2b, input logic [127:0] nkey);
        int cyc, n;
        logic [127:0] hk;
        logic [3:0] hr;
        bit st;
        n = 0; cyc = 0; st = 0; first_cyc = -1;
        expand_m(key);
        if (!pre) begin
            @(negedge clk);
            chk("done idle", done, 1'b0);
        end
        key_in = key;
        key_valid = 1'b1;
        chk("key_ready idle", key_ready, 1'b1);
        chk("busy idle", busy, 1'b0);
        while (n < 11 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            key_valid = junk;
            if (junk) key_in = {$urandom, $urandom, $urandom, $urandom};
            if (cyc == 5) begin
                chk("busy expand", busy, 1'b1);
                chk("key_ready expand", key_ready, 1'b0);
                chk("rk_valid expand", rk_valid, 1'b0);
            end
            if (st) begin
                chk("stall rk_out", rk_out, hk);
                chk("stall rk_round", rk_round, hr);
            end
            st = 0;
            if (rk_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (junk) chk("key_ready emit", key_ready, 1'b0);
                rk_ready = $urandom_range(99) < pct;
                if (rk_ready) begin
                    got_k[n] = rk_out;
                    got_r[n] = rk_round;
                    n++;
                end else begin
                    st = 1; hk = rk_out; hr = rk_round;
                end
            end else rk_ready = 1'($urandom_range(1));
            if (n == 11) begin
                key_valid = b2b;
                if (b2b) key_in = nkey;
            end
        end
        chk("stream length", n, 11);
        chk("latency to round 10", first_cyc, 11);
        for (int j = 0; j < n; j++) begin
            chk("round index", got_r[j], 10 - j);
            chk("round key", got_k[j], xf(mk[10 - j], 10 - j));
        end
        @(negedge clk);
        rk_ready = 1'b0;
        chk("done pulse", done, 1'b1);
        chk("rk_valid after r0", rk_valid, 1'b0);
        chk("key_ready in done", key_ready, 1'b1);
        chk("busy after r0", busy, 1'b0);
    endtask

    typedef struct {
        logic [127:0] key;
        int           rnd;
        logic [127:0] rk;
    } vec_t;

    localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQK = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        vec_t tv[5];
        logic [127:0] rk;
        tv[0] = '{FIPS, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tv[1] = '{FIPS, 9, 128'hac7766f319fadc2128d12941575c006e};
        tv[2] = '{FIPS, 1, 128'ha0fafe1788542cb123a339392a6c7605};
        tv[3] = '{FIPS, 0, FIPS};
        tv[4] = '{SEQK, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        build_sbox();

        repeat (2) @(negedge clk);
        chk("reset rk_valid", rk_valid, 1'b0);
        chk("reset rk_out", rk_out, '0);
        chk("reset rk_round", rk_round, 4'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run(tv[i].key, 100, 0, 0, 0, '0);
            chk("fips vector", got_k[10 - tv[i].rnd], xf(tv[i].rk, tv[i].rnd));
        end

        run(FIPS, 50, 0, 0, 0, '0);
        chk("backpressure round 1", got_k[9], xf(128'ha0fafe1788542cb123a339392a6c7605, 1));
        run(FIPS, 70, 1, 0, 0, '0);
        chk("ignored key round 10", got_k[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // reset during EXPAND
        @(negedge clk);
        key_in = FIPS;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy before reset", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst expand busy", busy, 1'b0);
        chk("rst expand rk_valid", rk_valid, 1'b0);
        chk("rst expand rk_round", rk_round, 4'd0);
        @(negedge clk) rst_n = 1'b1;
        chk("key_ready after reset", key_ready, 1'b1);

        // reset during EMIT at round 5
        expand_m(FIPS);
        key_in = FIPS;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        rk_ready = 1'b1;
        for (int i = 0; i < 40 && !(rk_valid && rk_round == 4'd5); i++) @(negedge clk);
        chk("reach round 5", rk_round, 4'd5);
        chk("round 5 key", rk_out, xf(mk[5], 5));
        #2 rst_n = 1'b0;
        #1;
        chk("rst emit rk_valid", rk_valid, 1'b0);
        chk("rst emit rk_out", rk_out, '0);
        chk("rst emit rk_round", rk_round, 4'd0);
        chk("rst emit done", done, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        rk_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("quiet after reset", rk_valid, 1'b0);
        end
        run(SEQK, 100, 0, 0, 0, '0);
        chk("seq key after reset", got_k[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // back-to-back: second key taken in the done cycle
        run(FIPS, 100, 0, 0, 1, SEQK);
        run(SEQK, 60, 0, 1, 0, '0);

        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            run(rk, int'($urandom_range(100, 30)), 1'($urandom_range(1)), 0, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
